// File: rtl/token_pkg.sv
// Shared types and default sizing for the token decimation/arbitration slice.
// The typedefs track the default build; the modules take their widths from parameters.
package token_pkg;

  localparam int PKG_N_CH      = 4;
  localparam int PKG_CNT_W     = 4;
  localparam int PKG_RATIO_W   = 3;
  localparam int PKG_DEF_RATIO = 2;
  localparam int PKG_CH_W      = $clog2(PKG_N_CH);

  typedef logic [PKG_CH_W-1:0]    ch_idx_t;
  typedef logic [PKG_RATIO_W-1:0] ratio_t;
  typedef logic [PKG_CNT_W-1:0]   pend_t;

  localparam pend_t PEND_MAX = '1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/token_decim_channel.sv
// One token channel: keep-1-of-K decimator feeding a saturating pending counter.
// A token lost to a full counter is reported one cycle later on drop.
module token_decim_channel #(
  parameter int CNT_W     = 4,
  parameter int RATIO_W   = 3,
  parameter int DEF_RATIO = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tok,
  input  logic               cfg_we,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic               grant,
  output logic               nonzero,
  output logic               drop
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic [RATIO_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               drop_q, drop_d;
  logic               promote;

  // A config write wins over a same-cycle token, and ratio 0 freezes the phase.
  always_comb begin
    ratio_d = ratio_q;
    phase_d = phase_q;
    promote = 1'b0;
    if (cfg_we) begin
      ratio_d = cfg_ratio;
      phase_d = '0;
    end else if (tok && (ratio_q != '0)) begin
      if (phase_q == (ratio_q - RATIO_W'(1))) begin
        phase_d = '0;
        promote = 1'b1;
      end else begin
        phase_d = phase_q + RATIO_W'(1);
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    drop_d = 1'b0;
    if (promote && !grant) begin
      if (pend_q == CNT_MAX) begin
        drop_d = 1'b1;
      end else begin
        pend_d = pend_q + CNT_W'(1);
      end
    end else if (!promote && grant) begin
      pend_d = pend_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ratio_q <= RATIO_W'(DEF_RATIO);
      phase_q <= '0;
      pend_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      ratio_q <= ratio_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign nonzero = (pend_q != '0);
  assign drop    = drop_q;

endmodule

// File: rtl/token_decim_arbiter.sv
// Decimates N_CH serial token streams and drains the surviving tokens round-robin
// into a single valid/ready output slot.
module token_decim_arbiter
  import token_pkg::*;
#(
  parameter int N_CH      = PKG_N_CH,
  parameter int CNT_W     = PKG_CNT_W,
  parameter int RATIO_W   = PKG_RATIO_W,
  parameter int DEF_RATIO = PKG_DEF_RATIO
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         tok_in,
  input  logic                    cfg_we,
  input  logic [$clog2(N_CH)-1:0] cfg_ch,
  input  logic [RATIO_W-1:0]      cfg_ratio,
  output logic                    out_valid,
  output logic [$clog2(N_CH)-1:0] out_ch,
  input  logic                    out_ready,
  output logic [N_CH-1:0]         drop
);

  localparam int CH_W = $clog2(N_CH);

  slot_state_e     state_q, state_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic [CH_W-1:0] last_q, last_d;
  logic [CH_W-1:0] win, idx;
  logic [N_CH-1:0] nonzero;
  logic [N_CH-1:0] grant;
  logic            found;
  logic            load;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    token_decim_channel #(
      .CNT_W    (CNT_W),
      .RATIO_W  (RATIO_W),
      .DEF_RATIO(DEF_RATIO)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tok      (tok_in[i]),
      .cfg_we   (cfg_we && (cfg_ch == CH_W'(i))),
      .cfg_ratio(cfg_ratio),
      .grant    (grant[i]),
      .nonzero  (nonzero[i]),
      .drop     (drop[i])
    );
  end

  // Round-robin search starts just after the last winner and wraps modulo N_CH.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = CH_W'((int'(last_q) + k) % N_CH);
      if (!found && nonzero[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    load     = (state_q == SLOT_EMPTY) || out_ready;
    state_d  = state_q;
    out_ch_d = out_ch_q;
    last_d   = last_q;
    grant    = '0;
    if (load) begin
      if (found) begin
        state_d     = SLOT_FULL;
        out_ch_d    = win;
        last_d      = win;
        grant[win]  = 1'b1;
      end else begin
        state_d = SLOT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SLOT_EMPTY;
      out_ch_q <= '0;
      last_q   <= CH_W'(N_CH - 1);
    end else begin
      state_q  <= state_d;
      out_ch_q <= out_ch_d;
      last_q   <= last_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_ch    = out_ch_q;

endmodule
